// File: rtl/tdc_enc_pkg.sv
// rtl/tdc_enc_pkg.sv - shared constants, fine-width helper and timestamp struct for the TDC encoder
package tdc_enc_pkg;

    localparam int DEF_TAPS       = 200;
    localparam int DEF_BUBBLE_WIN = 3;
    localparam int DEF_COARSE_W   = 16;

    // Fine code must hold 0..taps inclusive, hence taps+1 distinct values
    function automatic int fine_width(input int taps);
        return $clog2(taps + 1);
    endfunction

    localparam int DEF_FINE_W = fine_width(DEF_TAPS);

    typedef struct packed {
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine;
        logic                    overflow;
        logic                    bubble_err;
    } ts_t;

endpackage

// File: rtl/tdc_bubble_filter.sv
// rtl/tdc_bubble_filter.sv - windowed OR bubble filter and raw thermometer irregularity detect
module tdc_bubble_filter #(
    parameter int TAPS       = 200,
    parameter int BUBBLE_WIN = 3
) (
    input  logic [TAPS-1:0] t,
    output logic [TAPS-1:0] f,
    output logic            irregular
);

    // Each filtered tap looks forward across the window, clipped at the last tap
    for (genvar k = 0; k < TAPS; k++) begin : g_win
        localparam int HI = (k + BUBBLE_WIN - 1 < TAPS) ? (k + BUBBLE_WIN - 1) : (TAPS - 1);
        assign f[k] = |t[HI:k];
    end

    // A one above some zero always implies a 0->1 step between neighbouring taps
    assign irregular = |(t[TAPS-1:1] & ~t[TAPS-2:0]);

endmodule

// File: rtl/tdc_thermo_encoder_pipe.sv
// rtl/tdc_thermo_encoder_pipe.sv - 3-stage thermometer-to-binary TDC fine encoder (TDC_ENC_BUBBLE_CNT_EN enables bubble counter)
module tdc_thermo_encoder_pipe
    import tdc_enc_pkg::*;
#(
    parameter int TAPS       = DEF_TAPS,
    parameter int BUBBLE_WIN = DEF_BUBBLE_WIN,
    parameter int FINE_W     = fine_width(TAPS),
    parameter int COARSE_W   = DEF_COARSE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                hit_valid,
    input  logic [TAPS-1:0]     thermo_in,
    output logic                ts_valid,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                overflow,
    output logic                bubble_err,
    output logic [15:0]         bubble_cnt,
    input  logic                bubble_cnt_clr
);

    logic [COARSE_W-1:0] coarse_cnt;

    logic                v1;
    logic [TAPS-1:0]     t1;
    logic [COARSE_W-1:0] c1;

    logic [TAPS-1:0]     f_comb;
    logic                irr_comb;

    logic                v2;
    logic [TAPS-1:0]     f2;
    logic                irr2;
    logic [COARSE_W-1:0] c2;

    logic [FINE_W-1:0]   fine_comb;

    // Free-running coarse time base, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (rst) coarse_cnt <= '0;
        else     coarse_cnt <= coarse_cnt + 1'b1;
    end

    // S1: capture snapshot and coarse time of an accepted hit
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            t1 <= '0;
            c1 <= '0;
        end else begin
            v1 <= hit_valid && enable;
            if (hit_valid && enable) begin
                t1 <= thermo_in;
                c1 <= coarse_cnt;
            end
        end
    end

    tdc_bubble_filter #(
        .TAPS       (TAPS),
        .BUBBLE_WIN (BUBBLE_WIN)
    ) u_filter (
        .t         (t1),
        .f         (f_comb),
        .irregular (irr_comb)
    );

    // S2: register the filtered code and irregularity flag
    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            f2   <= '0;
            irr2 <= 1'b0;
            c2   <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                f2   <= f_comb;
                irr2 <= irr_comb;
                c2   <= c1;
            end
        end
    end

    // Fine code is the index of the lowest zero; all ones yields TAPS
    always_comb begin
        fine_comb = FINE_W'(TAPS);
        for (int k = TAPS - 1; k >= 0; k--) begin
            if (!f2[k]) fine_comb = FINE_W'(k);
        end
    end

    // S3: output registers; timestamp fields hold between valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_valid   <= 1'b0;
            ts_coarse  <= '0;
            ts_fine    <= '0;
            overflow   <= 1'b0;
            bubble_err <= 1'b0;
        end else begin
            ts_valid <= v2;
            if (v2) begin
                ts_coarse  <= c2;
                ts_fine    <= fine_comb;
                overflow   <= (fine_comb == FINE_W'(TAPS));
                bubble_err <= irr2;
            end
        end
    end

`ifdef TDC_ENC_BUBBLE_CNT_EN
    // Saturating count of bubbled timestamps, updated alongside the output word; clear wins
    always_ff @(posedge clk) begin
        if (rst)                                     bubble_cnt <= '0;
        else if (bubble_cnt_clr)                     bubble_cnt <= '0;
        else if (v2 && irr2 && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
`else
    logic unused_clr;
    assign unused_clr = bubble_cnt_clr;
    assign bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_tdc_thermo_encoder_pipe.sv
// tb/tb_tdc_thermo_encoder_pipe.sv - directed self-checking bench for tdc_thermo_encoder_pipe
module tb_tdc_thermo_encoder_pipe;
    import tdc_enc_pkg::*;

    localparam int TAPS = 200;
    localparam int FW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic            hit_valid = 1'b0;
    logic [TAPS-1:0] thermo_in = '0;
    logic            bubble_cnt_clr = 1'b0;

    logic            ts_valid, overflow, bubble_err;
    logic [15:0]     ts_coarse, bubble_cnt;
    logic [FW-1:0]   ts_fine;

    logic            ts_valid4, overflow4, bubble_err4;
    logic [3:0]      ts_coarse4;
    logic [FW-1:0]   ts_fine4;
    logic [15:0]     bubble_cnt4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tdc_thermo_encoder_pipe dut (
        .clk(clk), .rst(rst), .enable(enable), .hit_valid(hit_valid), .thermo_in(thermo_in),
        .ts_valid(ts_valid), .ts_coarse(ts_coarse), .ts_fine(ts_fine), .overflow(overflow),
        .bubble_err(bubble_err), .bubble_cnt(bubble_cnt), .bubble_cnt_clr(bubble_cnt_clr)
    );

    tdc_thermo_encoder_pipe #(.COARSE_W(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .hit_valid(hit_valid), .thermo_in(thermo_in),
        .ts_valid(ts_valid4), .ts_coarse(ts_coarse4), .ts_fine(ts_fine4), .overflow(overflow4),
        .bubble_err(bubble_err4), .bubble_cnt(bubble_cnt4), .bubble_cnt_clr(bubble_cnt_clr)
    );

    function automatic logic [TAPS-1:0] thermo(input int n);
        logic [TAPS-1:0] ones;
        ones = '1;
        return (n == 0) ? '0 : (ones >> (TAPS - n));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1; hit_valid = 1'b0; enable = 1'b1; bubble_cnt_clr = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    // Leaves time just after the edge that presents the hit's timestamp
    task automatic send_and_wait(input logic [TAPS-1:0] t);
        hit_valid = 1'b1; thermo_in = t;
        cyc();
        hit_valid = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; hit_valid = 1'b1; thermo_in = '1;
        cyc(); cyc();
        n_checks++; if (ts_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ts_valid); else n_pass++;
        n_checks++; if (ts_fine !== '0) $display("FAIL reset_fine got %0d want 0", ts_fine); else n_pass++;
        n_checks++; if (ts_coarse !== '0) $display("FAIL reset_coarse got %0d want 0", ts_coarse); else n_pass++;
        n_checks++; if ({overflow, bubble_err} !== 2'b00) $display("FAIL reset_flags got %b want 00", {overflow, bubble_err}); else n_pass++;
        n_checks++; if (bubble_cnt !== 16'd0) $display("FAIL reset_bcnt got %0d want 0", bubble_cnt); else n_pass++;
        rst = 1'b0; hit_valid = 1'b0;
        cyc(); cyc(); cyc();
        n_checks++; if (ts_valid !== 1'b0) $display("FAIL reset_nohit got %b want 0", ts_valid); else n_pass++;
    endtask

    task automatic test_clean();
        do_reset();
        idle(5);
        hit_valid = 1'b1; thermo_in = thermo(37);
        cyc();
        hit_valid = 1'b0;
        cyc();
        n_checks++; if (ts_valid !== 1'b0) $display("FAIL clean_early got %b want 0", ts_valid); else n_pass++;
        cyc();
        n_checks++; if (ts_valid !== 1'b1) $display("FAIL clean_valid got %b want 1", ts_valid); else n_pass++;
        n_checks++; if (ts_fine !== 8'd37) $display("FAIL clean_fine got %0d want 37", ts_fine); else n_pass++;
        n_checks++; if (ts_coarse !== 16'd5) $display("FAIL clean_coarse got %0d want 5", ts_coarse); else n_pass++;
        n_checks++; if ({overflow, bubble_err} !== 2'b00) $display("FAIL clean_flags got %b want 00", {overflow, bubble_err}); else n_pass++;
        cyc();
        n_checks++; if (ts_valid !== 1'b0) $display("FAIL clean_pulse got %b want 0", ts_valid); else n_pass++;
        n_checks++; if (ts_fine !== 8'd37 || ts_coarse !== 16'd5) $display("FAIL clean_hold got %0d/%0d want 37/5", ts_fine, ts_coarse); else n_pass++;
    endtask

    task automatic test_bubbles();
        logic [TAPS-1:0] vec [3];
        int exp_fine [3];
        vec[0] = thermo(50); vec[0][20] = 1'b0; vec[0][21] = 1'b0;                     exp_fine[0] = 50;
        vec[1] = thermo(50); vec[1][20] = 1'b0; vec[1][21] = 1'b0; vec[1][22] = 1'b0;  exp_fine[1] = 20;
        vec[2] = thermo(10); vec[2][150] = 1'b1;                                       exp_fine[2] = 10;
        for (int i = 0; i < 3; i++) begin
            send_and_wait(vec[i]);
            n_checks++; if (ts_valid !== 1'b1 || ts_fine !== FW'(exp_fine[i])) $display("FAIL bubble%0d_fine got v=%b %0d want v=1 %0d", i, ts_valid, ts_fine, exp_fine[i]); else n_pass++;
            n_checks++; if (bubble_err !== 1'b1 || overflow !== 1'b0) $display("FAIL bubble%0d_flags got err=%b ovf=%b want err=1 ovf=0", i, bubble_err, overflow); else n_pass++;
        end
    endtask

    task automatic test_extremes();
        int seen [TAPS+1];
        int bad;
        send_and_wait('1);
        n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 8'd200 || overflow !== 1'b1) $display("FAIL ones got v=%b %0d ovf=%b want v=1 200 ovf=1", ts_valid, ts_fine, overflow); else n_pass++;
        n_checks++; if (bubble_err !== 1'b0) $display("FAIL ones_bubble got %b want 0", bubble_err); else n_pass++;
        send_and_wait('0);
        n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 8'd0 || overflow !== 1'b0) $display("FAIL zeros got v=%b %0d ovf=%b want v=1 0 ovf=0", ts_valid, ts_fine, overflow); else n_pass++;
        for (int n = 0; n <= TAPS; n++) seen[n] = 0;
        for (int n = 0; n <= TAPS; n++) begin
            send_and_wait(thermo(n));
            n_checks++; if (ts_valid !== 1'b1 || ts_fine !== FW'(n)) $display("FAIL sweep%0d got v=%b %0d want v=1 %0d", n, ts_valid, ts_fine, n); else n_pass++;
            if (ts_fine <= FW'(TAPS)) seen[ts_fine]++;
        end
        bad = 0;
        for (int n = 0; n <= TAPS; n++) if (seen[n] != 1) bad++;
        n_checks++; if (bad != 0) $display("FAIL sweep_unique got %0d codes not seen once want 0", bad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        idle(15);
        hit_valid = 1'b1; thermo_in = thermo(100);
        cyc();
        thermo_in = thermo(101);
        cyc();
        hit_valid = 1'b0;
        cyc();
        n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 8'd100 || ts_coarse !== 16'd15) $display("FAIL b2b_first got v=%b %0d c=%0d want v=1 100 c=15", ts_valid, ts_fine, ts_coarse); else n_pass++;
        n_checks++; if (ts_valid4 !== 1'b1 || ts_coarse4 !== 4'd15) $display("FAIL wrap_first got v=%b c=%0d want v=1 c=15", ts_valid4, ts_coarse4); else n_pass++;
        cyc();
        n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 8'd101 || ts_coarse !== 16'd16) $display("FAIL b2b_second got v=%b %0d c=%0d want v=1 101 c=16", ts_valid, ts_fine, ts_coarse); else n_pass++;
        n_checks++; if (ts_valid4 !== 1'b1 || ts_coarse4 !== 4'd0) $display("FAIL wrap_second got v=%b c=%0d want v=1 c=0", ts_valid4, ts_coarse4); else n_pass++;
        cyc();
        n_checks++; if (ts_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", ts_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        do_reset();
        idle(2);
        hit_valid = 1'b1; thermo_in = thermo(60);
        cyc();
        hit_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (ts_valid !== 1'b0) seen_valid++;
            cyc();
        end
        n_checks++; if (seen_valid != 0) $display("FAIL rstmid_flush got %0d pulses want 0", seen_valid); else n_pass++;
        idle(3);
        send_and_wait(thermo(61));
        n_checks++; if (ts_valid !== 1'b1 || ts_coarse !== 16'd7 || ts_fine !== 8'd61) $display("FAIL rstmid_coarse got v=%b c=%0d f=%0d want v=1 c=7 f=61", ts_valid, ts_coarse, ts_fine); else n_pass++;
    endtask

    task automatic test_enable();
        int seen_valid;
        enable = 1'b1; hit_valid = 1'b1; thermo_in = thermo(5);
        cyc();
        enable = 1'b0; thermo_in = thermo(9);
        cyc();
        hit_valid = 1'b0;
        cyc();
        n_checks++; if (ts_valid !== 1'b1 || ts_fine !== 8'd5) $display("FAIL enable_inflight got v=%b %0d want v=1 5", ts_valid, ts_fine); else n_pass++;
        seen_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (ts_valid !== 1'b0) seen_valid++;
        end
        n_checks++; if (seen_valid != 0 || ts_fine !== 8'd5) $display("FAIL enable_drop got %0d pulses f=%0d want 0 pulses f=5", seen_valid, ts_fine); else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_bubble_cnt();
        logic [TAPS-1:0] bub;
        logic [15:0] exp3;
        bub = thermo(10); bub[150] = 1'b1;
`ifdef TDC_ENC_BUBBLE_CNT_EN
        exp3 = 16'd3;
`else
        exp3 = 16'd0;
`endif
        do_reset();
        hit_valid = 1'b1; thermo_in = bub;
        cyc(); cyc(); cyc();
        hit_valid = 1'b0;
        cyc(); cyc();
        n_checks++; if (bubble_cnt !== exp3) $display("FAIL bcnt_three got %0d want %0d", bubble_cnt, exp3); else n_pass++;
        hit_valid = 1'b1; thermo_in = bub;
        cyc();
        hit_valid = 1'b0;
        cyc();
        bubble_cnt_clr = 1'b1;
        cyc();
        bubble_cnt_clr = 1'b0;
        n_checks++; if (ts_valid !== 1'b1 || bubble_err !== 1'b1) $display("FAIL bcnt_hit got v=%b err=%b want v=1 err=1", ts_valid, bubble_err); else n_pass++;
        n_checks++; if (bubble_cnt !== 16'd0) $display("FAIL bcnt_clr got %0d want 0", bubble_cnt); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_clean();
        test_bubbles();
        test_extremes();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_bubble_cnt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tdc_thermo_encoder_pipe.md
Name: tdc_thermo_encoder_pipe

Overview:
- Pipelined, parametrised thermometer-to-binary fine-time encoder for the TDC tapped delay line.
- Captures one delay-line snapshot per hit and applies a configurable-window bubble filter.
- Encodes the filtered snapshot to a gap-free binary fine code and tags it with a free-running coarse counter value.
- Sits between the delay-line sampling flops and the hit FIFO/readout; the output is a timestamp word plus status flags.

Parameters:
- TAPS, 200, number of delay-line taps (thermometer width), >= 4.
- BUBBLE_WIN, 3, bubble-filter window in taps, 1..8; 1 means no filtering.
- FINE_W, $clog2(TAPS+1), fine code width (8 at TAPS=200).
- COARSE_W, 16, coarse counter width.

Ports:
- clk, input, 1, system clock; delay-line snapshot is synchronous to it.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, gates hit acceptance; coarse counter runs regardless.
- hit_valid, input, 1, thermo_in holds a valid snapshot this cycle.
- thermo_in, input, TAPS, raw delay-line snapshot; bit 0 = first tap.
- ts_valid, output, 1, one-cycle pulse; timestamp outputs valid.
- ts_coarse, output, COARSE_W, coarse count captured at the hit cycle.
- ts_fine, output, FINE_W, corrected fine code 0..TAPS.
- overflow, output, 1, filtered code is all ones (ts_fine = TAPS).
- bubble_err, output, 1, raw snapshot was not a pure thermometer code.
- bubble_cnt, output, 16, saturating bubble-event count (optional feature).
- bubble_cnt_clr, input, 1, clears bubble_cnt (optional feature).

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; all pipeline valids 0; coarse counter 0; bubble_cnt 0.
- Coarse counter: increments by 1 every cycle when not in reset; wraps from 2^COARSE_W-1 to 0.
- S1, capture: if hit_valid && enable, register thermo_in, the current coarse value and v1=1; otherwise v1=0. Capture does not depend on the downstream stages (no back-pressure).
- S2, filter:
  - f[k] = OR of t[k .. min(k+BUBBLE_WIN-1, TAPS-1)].
  - Raw-irregularity flag = 1 if any t[j]=1 with t[i]=0 for some i<j.
  - Register f, the flag, coarse and valid.
- S3, encode:
  - fine = number of contiguous ones in f starting at bit 0 (index of the first zero, or TAPS if none).
  - overflow = (fine == TAPS).
  - Register to outputs; ts_valid = v3.
- Latency: exactly 3 cycles, from a hit_valid cycle N to ts_valid at cycle N+3.
- Throughput: one hit per cycle. Back-to-back hits produce back-to-back ts_valid pulses.
- Code map: monotonic, with every value 0..TAPS reachable and no missing or duplicated codes.
- Snapshot cases:
  - All-zero snapshot: fine=0, overflow=0, ts_valid still pulses.
  - Ones separated from the main run by a gap of >= BUBBLE_WIN zeros are ignored for fine, but still set bubble_err.
- Output hold: when ts_valid=0, ts_coarse, ts_fine, overflow and bubble_err hold their last values.
- rst mid-operation: all in-flight hits are discarded, no ts_valid follows, and the counter restarts at 0 on the cycle after rst deasserts.
- enable=0: hits are dropped silently; hits already in flight complete.

Optional Feature:
- Macro: TDC_ENC_BUBBLE_CNT_EN.
- With the macro defined:
  - bubble_cnt increments on each ts_valid with bubble_err=1 and saturates at 0xFFFF.
  - bubble_cnt_clr=1 sets it to 0 next cycle, taking priority over a simultaneous increment.
- Without the macro: the ports remain; bubble_cnt is tied to 0 and bubble_cnt_clr is ignored.

Decomposition:
- Package tdc_enc_pkg: default TAPS/BUBBLE_WIN/COARSE_W constants, a clog2-based FINE_W helper, and a timestamp struct typedef {coarse, fine, overflow, bubble_err}.
- Sub-module tdc_bubble_filter (combinational, parametrised TAPS/BUBBLE_WIN): produces f and the irregularity flag. It is instantiated in S2.

Test Plan (TAPS=200, BUBBLE_WIN=3 unless noted):
1. Clean code: bits [36:0]=1 with a hit at coarse=5 -> 3 cycles later ts_valid=1, ts_fine=37, ts_coarse=5, bubble_err=0, overflow=0.
2. Bubbles:
   - Bits [49:0]=1 except bits 20,21 = 0 -> ts_fine=50, bubble_err=1.
   - Bits 20,21,22 = 0 instead -> ts_fine=20, bubble_err=1.
   - Bits [9:0] plus bit 150 -> ts_fine=10, bubble_err=1.
3. Extremes: all ones -> ts_fine=200, overflow=1; all zeros -> ts_fine=0, overflow=0, ts_valid=1. Sweep fine 0..200 -> every code is seen exactly once.
4. Back-to-back hits on consecutive cycles with codes 100 then 101 -> consecutive ts_valid pulses with fine 100 then 101 and coarse differing by 1.
5. Reset: assert rst one cycle after a hit -> no ts_valid; the first post-reset hit reports coarse = cycles since rst deasserted minus 1.
6. COARSE_W=4: hits at counts 15 and 0 -> ts_coarse=15 then 0. With TDC_ENC_BUBBLE_CNT_EN: 3 bubbled hits give bubble_cnt=3, and clr together with a bubbled hit gives 0.
